mem_controller: RTL and testbench

MEM_CONTROLLER -- requirements
Module: mem_controller

---
 rtl/mem_controller.sv | 140 ++++++++++++++
 tb/tb_mem_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_controller.sv
// mem_controller: serialises single-word CPU read/write requests onto a
// synchronous RAM with a registered read port and a shared tri-state data bus.
// Every RAM-side and CPU-side output comes straight from a flop, so strobes
// and the bus enable are glitch-free and drop immediately on reset.
module mem_controller #(
    parameter int adlines   = 8,
    parameter int datalines = 32,
    parameter int ramsize   = 256
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req,
    input  logic                 i_we,
    input  logic [adlines-1:0]   i_addr,
    input  logic [datalines-1:0] i_wdata,
    output logic                 o_ack,
    output logic                 o_err,
    output logic [datalines-1:0] o_rdata,
    output logic                 o_busy,
    output logic [adlines-1:0]   o_mem_address,
    inout  wire  [datalines-1:0] io_mem_data,
    output logic                 o_mem_read,
    output logic                 o_mem_write
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_ACK
    } state_t;

    state_t                 r_state;
    logic [datalines-1:0]   r_wdata;
    logic [datalines-1:0]   r_rdata;
    logic [adlines-1:0]     r_mem_address;
    logic                   r_drive;
    logic                   r_ack;
    logic                   r_err;
    logic                   r_busy;
    logic                   r_mem_read;
    logic                   r_mem_write;
    logic                   w_out_of_range;

    // When the RAM covers the whole address space no request can be out of
    // range, so the comparator is removed entirely.
    generate
        if (ramsize >= (1 << adlines)) begin : g_full_range
            assign w_out_of_range = 1'b0;
        end else begin : g_partial_range
            assign w_out_of_range = (i_addr >= adlines'(ramsize));
        end
    endgenerate

    // Controller FSM; outputs are registered alongside the state so each one
    // is already valid in the first cycle of the state it belongs to.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_mem_address <= '0;
            r_drive       <= 1'b0;
            r_ack         <= 1'b0;
            r_err         <= 1'b0;
            r_busy        <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req) begin
                        // The request type is carried forward by the choice of next state.
                        r_mem_address <= i_addr;
                        r_wdata       <= i_wdata;
                        r_busy        <= 1'b1;
                        if (w_out_of_range) begin
                            // Rejected requests complete without touching the RAM.
                            r_state <= ST_ACK;
                            r_ack   <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (i_we) begin
                            r_state     <= ST_WR;
                            r_mem_write <= 1'b1;
                            r_drive     <= 1'b1;
                        end else begin
                            r_state <= ST_RD_ADDR;
                        end
                    end
                end
                ST_WR: begin
                    // RAM captures address and data on this exiting edge.
                    r_state     <= ST_ACK;
                    r_mem_write <= 1'b0;
                    r_drive     <= 1'b0;
                    r_ack       <= 1'b1;
                end
                ST_RD_ADDR: begin
                    // RAM loads its output register on this edge; enable its bus driver next.
                    r_state    <= ST_RD_DATA;
                    r_mem_read <= 1'b1;
                end
                ST_RD_DATA: begin
                    r_state    <= ST_ACK;
                    r_mem_read <= 1'b0;
                    r_rdata    <= io_mem_data;
                    r_ack      <= 1'b1;
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_ack       <= 1'b0;
                    r_err       <= 1'b0;
                    r_busy      <= 1'b0;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_drive     <= 1'b0;
                end
            endcase
        end
    end

    // The bus is only driven during a write, never alongside mem_read.
    assign io_mem_data   = r_drive ? r_wdata : {datalines{1'bz}};

    assign o_ack         = r_ack;
    assign o_err         = r_err;
    assign o_rdata       = r_rdata;
    assign o_busy        = r_busy;
    assign o_mem_address = r_mem_address;
    assign o_mem_read    = r_mem_read;
    assign o_mem_write   = r_mem_write;

endmodule

// File: tb/tb_mem_controller.sv
// Testbench for mem_controller: a behavioural synchronous RAM on the bus,
// directed transactions, and a scoreboard monitor checking every ack and
// every write strobe against expectations pushed by the stimulus.
module tb_mem_controller;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int RS = 200;

    logic          clk;
    logic          rst_n;
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic          err;
    logic [DW-1:0] rdata;
    logic          busy;
    logic [AW-1:0] mem_address;
    wire  [DW-1:0] mem_data;
    logic          mem_read;
    logic          mem_write;

    mem_controller #(.adlines(AW), .datalines(DW), .ramsize(RS)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req         (req),
        .i_we          (we),
        .i_addr        (addr),
        .i_wdata       (wdata),
        .o_ack         (ack),
        .o_err         (err),
        .o_rdata       (rdata),
        .o_busy        (busy),
        .o_mem_address (mem_address),
        .io_mem_data   (mem_data),
        .o_mem_read    (mem_read),
        .o_mem_write   (mem_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM with a registered read port; drives the bus while mem_read is high.
    logic [DW-1:0] ram [0:255];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (mem_write) ram[mem_address] <= mem_data;
        ram_q <= ram[mem_address];
    end
    assign mem_data = mem_read ? ram_q : {DW{1'bz}};

    typedef struct {
        int            cyc;
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          sb[$];
    logic [39:0]   wq[$];
    logic [DW-1:0] model_mem [0:255];
    logic [DW-1:0] model_rdata;
    int            exp_reads;
    int            read_pulses;
    int            checks;
    int            errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One transaction: drive, accept on the next edge, then wait out its schedule.
    // hold keeps req high for a back-to-back successor; junk presents a decoy
    // request while busy, which must be ignored.
    task automatic txn(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit hold, input bit junk);
        exp_t e;
        int   period;
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        chk("busy_before_accept", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        e.cyc = cyc;
        if (int'(a) >= RS) begin
            e.err   = 1'b1;
            e.rdata = model_rdata;
            period  = 2;
        end else if (w) begin
            e.cyc   = cyc + 1;
            e.err   = 1'b0;
            e.rdata = model_rdata;
            model_mem[a] = d;
            wq.push_back({a, d});
            period  = 3;
        end else begin
            e.cyc   = cyc + 2;
            e.err   = 1'b0;
            model_rdata = model_mem[a];
            e.rdata = model_rdata;
            exp_reads++;
            period  = 4;
        end
        sb.push_back(e);
        $display("txn: we=%0d addr=%0d wdata=%h accepted at cycle %0d", w, a, d, cyc);
        chk("busy_after_accept", 64'(busy), 64'd1);
        if (junk) begin
            we    = ~w;
            addr  = 8'd250;
            wdata = 32'h0BAD_0BAD;
        end else if (!hold) begin
            req = 1'b0;
        end
        repeat (period - 1) @(posedge clk);
        #1;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        exp_reads   = 0;
        read_pulses = 0;
        model_rdata = '0;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        rst_n = 1'b0;

        // Scoreboard monitor, sampling on the falling edge.
        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    if (mem_read || mem_write)
                        chk("strobe_overlap", 64'(mem_read & mem_write), 64'd0);
                    if (mem_read) read_pulses++;
                    if (mem_write) begin
                        if (wq.size() == 0) begin
                            chk("unexpected_write", 64'(mem_write), 64'd0);
                        end else begin
                            logic [39:0] wexp;
                            wexp = wq.pop_front();
                            chk("write_addr", 64'(mem_address), 64'(wexp[39:32]));
                            chk("write_data", 64'(mem_data), 64'(wexp[31:0]));
                        end
                    end
                    if (ack) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_ack", 64'(ack), 64'd0);
                        end else begin
                            exp_t e;
                            e = sb.pop_front();
                            chk("ack_cycle", 64'(cyc), 64'(e.cyc));
                            chk("ack_err", 64'(err), 64'(e.err));
                            chk("ack_rdata", 64'(rdata), 64'(e.rdata));
                            $display("ack: cycle %0d err=%0d rdata=%h", cyc, err, rdata);
                        end
                    end
                end
            end
        join_none

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mem_read", 64'(mem_read), 64'd0);
        chk("rst_mem_write", 64'(mem_write), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_mem_address", 64'(mem_address), 64'd0);
        chk("rst_bus_hiz", 64'(mem_data === {DW{1'bz}}), 64'd1);

        // First edge after release samples req.
        @(negedge clk);
        rst_n = 1'b1;
        txn(1'b1, 8'd5,   32'hDEADBEEF, 1'b0, 1'b0);
        txn(1'b0, 8'd5,   32'h0,        1'b0, 1'b0);
        txn(1'b1, 8'd199, 32'h12345678, 1'b0, 1'b0);
        txn(1'b0, 8'd199, 32'h0,        1'b0, 1'b0);
        txn(1'b0, 8'd200, 32'h0,        1'b0, 1'b0);
        txn(1'b0, 8'd250, 32'h0,        1'b0, 1'b0);
        txn(1'b1, 8'd255, 32'hFFFF0000, 1'b0, 1'b0);

        // Back-to-back with req held high and alternating we.
        txn(1'b1, 8'd10, 32'hA5A5A5A5, 1'b1, 1'b0);
        txn(1'b0, 8'd10, 32'h0,        1'b1, 1'b0);
        txn(1'b1, 8'd11, 32'h0F0F0F0F, 1'b1, 1'b0);
        txn(1'b0, 8'd11, 32'h0,        1'b0, 1'b0);

        // Decoy request while busy, real request present at the IDLE edge.
        txn(1'b1, 8'd20, 32'hCAFEF00D, 1'b0, 1'b1);
        txn(1'b0, 8'd20, 32'h0,        1'b0, 1'b0);

        // Reset during RD_DATA aborts the read without an ack.
        req  = 1'b1;
        we   = 1'b0;
        addr = 8'd5;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_rdata = '0;
        chk("abort_mem_read", 64'(mem_read), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ack", 64'(ack), 64'd0);
        chk("abort_rdata", 64'(rdata), 64'd0);
        chk("abort_bus_hiz", 64'(mem_data === {DW{1'bz}}), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("no_ack_after_abort", 64'(sb.size()), 64'd0);

        // RAM contents survive reset.
        txn(1'b0, 8'd199, 32'h0, 1'b0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("pending_acks", 64'(sb.size()), 64'd0);
        chk("pending_writes", 64'(wq.size()), 64'd0);
        chk("read_pulse_count", 64'(read_pulses), 64'(exp_reads));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
